// File: rtl/regbus_pkg.sv
// Shared types and constants for the register-transfer controller.
// REG_XFER_SWAP_EN adds the RD2/WR2 states used by the SWAP command.
package regbus_pkg;

    localparam int XLEN      = 32;
    localparam int REG_IDX_W = 5;

    localparam logic [XLEN-1:0]      WORD_ZERO = {XLEN{1'b0}};
    localparam logic [REG_IDX_W-1:0] IDX_ZERO  = {REG_IDX_W{1'b0}};

    typedef enum logic [1:0] {
        OP_MOVE  = 2'b00,
        OP_LOADI = 2'b01,
        OP_READ  = 2'b10,
        OP_SWAP  = 2'b11
    } op_e;

`ifdef REG_XFER_SWAP_EN
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_GAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4,
        ST_RD2  = 3'd5,
        ST_WR2  = 3'd6
    } state_e;
`else
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_GAP  = 3'd2,
        ST_WR   = 3'd3,
        ST_RSP  = 3'd4
    } state_e;
`endif

    // Without SWAP, op 11 is a NOP that spends one quiet cycle in GAP.
    function automatic state_e first_state(op_e op);
        case (op)
            OP_MOVE:  return ST_RD;
            OP_READ:  return ST_RD;
            OP_LOADI: return ST_WR;
`ifdef REG_XFER_SWAP_EN
            OP_SWAP:  return ST_RD;
`else
            OP_SWAP:  return ST_GAP;
`endif
            default:  return ST_IDLE;
        endcase
    endfunction

endpackage

// File: rtl/reg_xfer_ctrl_chk.sv
// Property checker for reg_xfer_ctrl: bus contention and handshake sanity.
module reg_xfer_ctrl_chk (
    input logic clk,
    input logic rst,
    input logic reg_en,
    input logic bus_oe,
    input logic cmd_ready,
    input logic busy
);

    a_no_contention: assert property (@(posedge clk) disable iff (!rst) !(reg_en && bus_oe));

    a_ready_only_idle: assert property (@(posedge clk) disable iff (!rst) !(cmd_ready && busy));

endmodule

// File: rtl/reg_xfer_ctrl.sv
// Register-file bus initiator: MOVE / LOADI / READ and op 11 (SWAP when
// REG_XFER_SWAP_EN is defined, otherwise NOP). All outputs are flops.
module reg_xfer_ctrl
    import regbus_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [1:0]           cmd_op,
    input  logic [REG_IDX_W-1:0] cmd_rs,
    input  logic [REG_IDX_W-1:0] cmd_rd,
    input  logic [XLEN-1:0]      cmd_imm,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [XLEN-1:0]      rsp_data,
    input  logic [XLEN-1:0]      bus_in,
    output logic [XLEN-1:0]      bus_out,
    output logic                 bus_oe,
    output logic [REG_IDX_W-1:0] reg_idx,
    output logic                 reg_en,
    output logic                 reg_write,
    output logic                 busy
);

    state_e                 state_q, state_d;
    op_e                    op_q, op_d;
    logic [REG_IDX_W-1:0]   rs_q, rs_d, rd_q, rd_d;
    logic [XLEN-1:0]        hold_q, hold_d;
`ifdef REG_XFER_SWAP_EN
    logic [XLEN-1:0]        hold2_q, hold2_d;
`endif

    logic                   cmd_ready_q, cmd_ready_d;
    logic                   busy_q, busy_d;
    logic                   reg_en_q, reg_en_d;
    logic                   reg_write_q, reg_write_d;
    logic                   bus_oe_q, bus_oe_d;
    logic [REG_IDX_W-1:0]   reg_idx_q, reg_idx_d;
    logic [XLEN-1:0]        bus_out_q, bus_out_d;
    logic                   rsp_valid_q, rsp_valid_d;
    logic [XLEN-1:0]        rsp_data_q, rsp_data_d;

    // Next-state and operand capture.
    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rd_d    = rd_q;
        hold_d  = hold_q;
`ifdef REG_XFER_SWAP_EN
        hold2_d = hold2_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready_q) begin
                    op_d    = op_e'(cmd_op);
                    rs_d    = cmd_rs;
                    rd_d    = cmd_rd;
                    state_d = first_state(op_e'(cmd_op));
                    if (op_e'(cmd_op) == OP_LOADI) begin
                        hold_d = cmd_imm;
                    end else begin
                        hold_d = hold_q;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                hold_d = bus_in;
                if (op_q == OP_READ) begin
                    state_d = ST_RSP;
`ifdef REG_XFER_SWAP_EN
                end else if (op_q == OP_SWAP) begin
                    state_d = ST_RD2;
`endif
                end else begin
                    state_d = ST_GAP;
                end
            end
`ifdef REG_XFER_SWAP_EN
            ST_RD2: begin
                hold2_d = bus_in;
                state_d = ST_GAP;
            end
            ST_WR2: begin
                state_d = ST_IDLE;
            end
`endif
            ST_GAP: begin
                // GAP leaves the bus undriven so a read never abuts a write.
                if (op_q == OP_MOVE) begin
                    state_d = ST_WR;
`ifdef REG_XFER_SWAP_EN
                end else if (op_q == OP_SWAP) begin
                    state_d = ST_WR;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR: begin
`ifdef REG_XFER_SWAP_EN
                if (op_q == OP_SWAP) begin
                    state_d = ST_WR2;
                end else begin
                    state_d = ST_IDLE;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RSP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output decode of the upcoming state, so every port comes from a flop.
    always_comb begin
        cmd_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE);
        reg_en_d    = 1'b0;
        reg_write_d = 1'b0;
        bus_oe_d    = 1'b0;
        reg_idx_d   = IDX_ZERO;
        bus_out_d   = WORD_ZERO;
        rsp_valid_d = 1'b0;
        rsp_data_d  = WORD_ZERO;
        case (state_d)
            ST_RD: begin
                reg_en_d  = 1'b1;
                reg_idx_d = rs_d;
            end
            ST_WR: begin
                bus_oe_d    = 1'b1;
                reg_write_d = 1'b1;
                reg_idx_d   = rd_d;
                bus_out_d   = hold_d;
            end
`ifdef REG_XFER_SWAP_EN
            ST_RD2: begin
                reg_en_d  = 1'b1;
                reg_idx_d = rd_d;
            end
            ST_WR2: begin
                bus_oe_d    = 1'b1;
                reg_write_d = 1'b1;
                reg_idx_d   = rs_d;
                bus_out_d   = hold2_d;
            end
`endif
            ST_RSP: begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = hold_d;
            end
            default: begin
                reg_en_d = 1'b0;
            end
        endcase
    end

    // State, operand and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_MOVE;
            rs_q        <= IDX_ZERO;
            rd_q        <= IDX_ZERO;
            hold_q      <= WORD_ZERO;
`ifdef REG_XFER_SWAP_EN
            hold2_q     <= WORD_ZERO;
`endif
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b0;
            reg_en_q    <= 1'b0;
            reg_write_q <= 1'b0;
            bus_oe_q    <= 1'b0;
            reg_idx_q   <= IDX_ZERO;
            bus_out_q   <= WORD_ZERO;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= WORD_ZERO;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            rs_q        <= rs_d;
            rd_q        <= rd_d;
            hold_q      <= hold_d;
`ifdef REG_XFER_SWAP_EN
            hold2_q     <= hold2_d;
`endif
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
            reg_en_q    <= reg_en_d;
            reg_write_q <= reg_write_d;
            bus_oe_q    <= bus_oe_d;
            reg_idx_q   <= reg_idx_d;
            bus_out_q   <= bus_out_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign reg_en    = reg_en_q;
    assign reg_write = reg_write_q;
    assign bus_oe    = bus_oe_q;
    assign reg_idx   = reg_idx_q;
    assign bus_out   = bus_out_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_reg_xfer_ctrl.sv
// Bench for reg_xfer_ctrl: a behavioural register file on the shared bus and a
// command-level model that predicts each cycle of bus activity and final contents.
module tb_reg_xfer_ctrl;
    import regbus_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready;
    logic [1:0]  cmd_op;
    logic [4:0]  cmd_rs, cmd_rd;
    logic [31:0] cmd_imm;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_data;
    logic [31:0] bus_in, bus_out;
    logic        bus_oe;
    logic [4:0]  reg_idx;
    logic        reg_en, reg_write, busy;

    logic [31:0] rf [32];
    logic [31:0] rf_seed [32];
    logic [31:0] mregs [32];
    logic        load_rf;

    int checks = 0;
    int failures = 0;
    int overlap_cnt = 0;

    typedef struct {
        logic        en;
        logic        oe;
        logic        wr;
        logic [4:0]  idx;
        logic [31:0] data;
    } step_t;

    always #5 clk = ~clk;

    reg_xfer_ctrl dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_rs(cmd_rs), .cmd_rd(cmd_rd), .cmd_imm(cmd_imm),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .bus_in(bus_in), .bus_out(bus_out), .bus_oe(bus_oe),
        .reg_idx(reg_idx), .reg_en(reg_en), .reg_write(reg_write), .busy(busy)
    );

    reg_xfer_ctrl_chk u_chk (
        .clk(clk), .rst(rst), .reg_en(reg_en), .bus_oe(bus_oe),
        .cmd_ready(cmd_ready), .busy(busy)
    );

    // Resolved bus: our drive wins, else the file drives on reg_en; index 0 reads as zero.
    assign bus_in = bus_oe ? bus_out : (reg_en ? ((reg_idx == 5'd0) ? 32'h0 : rf[reg_idx]) : 32'h0);

    always @(posedge clk) begin
        if (load_rf) begin
            for (int i = 0; i < 32; i++) rf[i] <= rf_seed[i];
        end else if (reg_write && bus_oe && reg_idx != 5'd0) begin
            rf[reg_idx] <= bus_in;
        end
    end

    always @(negedge clk) begin
        if (reg_en && bus_oe) overlap_cnt++;
    end

    task automatic chk_val(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] pk(logic bsy, logic rdy, logic en, logic oe, logic wr,
                                       logic [4:0] idx, logic [31:0] bo, logic rv, logic [31:0] rdat);
        return {5'd0, bsy, rdy, en, oe, wr, idx, bo, rv, rdat};
    endfunction

    function automatic logic [79:0] obs_vec();
        return pk(busy, cmd_ready, reg_en, bus_oe, reg_write, reg_idx, bus_out, rsp_valid, rsp_data);
    endfunction

    function automatic step_t mk(logic en, logic oe, logic wr, logic [4:0] idx, logic [31:0] data);
        step_t s;
        s.en = en; s.oe = oe; s.wr = wr; s.idx = idx; s.data = data;
        return s;
    endfunction

    function automatic logic [31:0] val(logic [4:0] r);
        return (r == 5'd0) ? 32'h0 : mregs[r];
    endfunction

    function automatic void mwrite(logic [4:0] r, logic [31:0] v);
        if (r != 5'd0) mregs[r] = v;
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!cmd_ready && n < 20) begin
            tick();
            n++;
        end
        chk_val("ready_wait", {79'd0, cmd_ready}, 80'd1);
    endtask

    // Issue one command and compare every cycle until the block is idle again.
    task automatic do_cmd(input logic [1:0] op, input logic [4:0] rs, input logic [4:0] rd,
                          input logic [31:0] imm, input int hold_cycles);
        step_t       tr[$];
        logic [31:0] a, b;
        a = val(rs);
        b = val(rd);
        case (op)
            2'b00: begin
                tr.push_back(mk(1'b1, 1'b0, 1'b0, rs, 32'h0));
                tr.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
                tr.push_back(mk(1'b0, 1'b1, 1'b1, rd, a));
                mwrite(rd, a);
            end
            2'b01: begin
                tr.push_back(mk(1'b0, 1'b1, 1'b1, rd, imm));
                mwrite(rd, imm);
            end
            2'b10: begin
                tr.push_back(mk(1'b1, 1'b0, 1'b0, rs, 32'h0));
            end
            default: begin
`ifdef REG_XFER_SWAP_EN
                tr.push_back(mk(1'b1, 1'b0, 1'b0, rs, 32'h0));
                tr.push_back(mk(1'b1, 1'b0, 1'b0, rd, 32'h0));
                tr.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
                tr.push_back(mk(1'b0, 1'b1, 1'b1, rd, a));
                tr.push_back(mk(1'b0, 1'b1, 1'b1, rs, b));
                mwrite(rd, a);
                mwrite(rs, b);
`else
                tr.push_back(mk(1'b0, 1'b0, 1'b0, 5'd0, 32'h0));
`endif
            end
        endcase

        wait_ready();
        cmd_valid = 1'b1; cmd_op = op; cmd_rs = rs; cmd_rd = rd; cmd_imm = imm;
        for (int i = 0; i < tr.size(); i++) begin
            tick();
            // Junk on the command port while busy must be ignored.
            cmd_op = 2'($urandom); cmd_rs = 5'($urandom); cmd_rd = 5'($urandom); cmd_imm = $urandom;
            chk_val("xfer_step", obs_vec(), pk(1'b1, 1'b0, tr[i].en, tr[i].oe, tr[i].wr, tr[i].idx, tr[i].data, 1'b0, 32'h0));
            if (i == tr.size() - 1 && op != 2'b10) cmd_valid = 1'b0;
        end
        if (op == 2'b10) begin
            for (int i = 0; i <= hold_cycles; i++) begin
                tick();
                chk_val("rsp_hold", obs_vec(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, a));
                if (i == hold_cycles) begin
                    rsp_ready = 1'b1;
                    cmd_valid = 1'b0;
                end
            end
        end
        tick();
        rsp_ready = 1'b0;
        chk_val("back_idle", obs_vec(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0));
        chk_val("rf_rd", {48'd0, rf[rd]}, {48'd0, mregs[rd]});
        chk_val("rf_rs", {48'd0, rf[rs]}, {48'd0, mregs[rs]});
    endtask

    task automatic reset_mid_move(input logic [4:0] rs, input logic [4:0] rd);
        wait_ready();
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_rs = rs; cmd_rd = rd; cmd_imm = 32'h0;
        tick();
        cmd_valid = 1'b0;
        chk_val("rst_rd", obs_vec(), pk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, rs, 32'h0, 1'b0, 32'h0));
        tick();
        chk_val("rst_gap", obs_vec(), pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0));
        #1 rst = 1'b0;
        #1 chk_val("rst_async", obs_vec(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0));
        tick();
        chk_val("rst_low", obs_vec(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0));
        tick();
        rst = 1'b1;
        tick();
        chk_val("rst_release", obs_vec(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0));
        chk_val("rst_no_write", {48'd0, rf[rd]}, {48'd0, mregs[rd]});
    endtask

    initial begin
        rst = 1'b0;
        cmd_valid = 1'b0; cmd_op = 2'b00; cmd_rs = 5'd0; cmd_rd = 5'd0; cmd_imm = 32'h0;
        rsp_ready = 1'b0;
        load_rf = 1'b1;
        for (int i = 0; i < 32; i++) begin
            rf_seed[i] = (i == 0) ? 32'h0 : $urandom;
            mregs[i] = rf_seed[i];
        end
        #1;
        chk_val("reset_state", obs_vec(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0));
        tick();
        tick();
        load_rf = 1'b0;
        chk_val("reset_hold", obs_vec(), pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0));
        rst = 1'b1;
        tick();
        chk_val("post_reset", obs_vec(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0));

        do_cmd(2'b01, 5'd0, 5'd5, 32'hDEADBEEF, 0);
        do_cmd(2'b00, 5'd5, 5'd7, 32'h0, 0);
        chk_val("move_r7", {48'd0, rf[7]}, {48'd0, 32'hDEADBEEF});
        do_cmd(2'b10, 5'd7, 5'd0, 32'h0, 4);
        do_cmd(2'b01, 5'd0, 5'd0, 32'h12345678, 0);
        do_cmd(2'b10, 5'd0, 5'd3, 32'h0, 1);
        do_cmd(2'b01, 5'd0, 5'd1, 32'h11, 0);
        do_cmd(2'b01, 5'd0, 5'd2, 32'h22, 0);
        do_cmd(2'b11, 5'd1, 5'd2, 32'h0, 0);
`ifdef REG_XFER_SWAP_EN
        chk_val("op11_r1", {48'd0, rf[1]}, {48'd0, 32'h22});
        chk_val("op11_r2", {48'd0, rf[2]}, {48'd0, 32'h11});
`else
        chk_val("op11_r1", {48'd0, rf[1]}, {48'd0, 32'h11});
        chk_val("op11_r2", {48'd0, rf[2]}, {48'd0, 32'h22});
`endif
        do_cmd(2'b01, 5'd0, 5'd3, 32'hA5A5_0001, 0);
        do_cmd(2'b01, 5'd0, 5'd4, 32'h5A5A_0002, 0);
        reset_mid_move(5'd3, 5'd4);

        for (int n = 0; n < 200; n++) begin
            int idle_cycles;
            do_cmd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                   $urandom, int'($urandom_range(0, 3)));
            idle_cycles = int'($urandom_range(0, 2));
            for (int k = 0; k < idle_cycles; k++) begin
                tick();
                chk_val("idle_gap", obs_vec(), pk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 32'h0));
            end
        end

        for (int i = 0; i < 32; i++) begin
            chk_val("final_rf", {48'd0, rf[i]}, {48'd0, mregs[i]});
        end
        chk_val("no_overlap", {48'd0, 32'(overlap_cnt)}, 80'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/reg_xfer_ctrl.md
REG_XFER_CTRL -- requirements
Module: reg_xfer_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: cmd_valid in 1, cmd_ready out 1  command handshake.
REQ-004 SHALL have ports: cmd_op in 2 (00 MOVE, 01 LOADI, 10 READ, 11 SWAP/NOP), cmd_rs in 5, cmd_rd in 5, cmd_imm in 32.
REQ-005 SHALL have ports: rsp_valid out 1, rsp_ready in 1, rsp_data out 32  READ result handshake.
REQ-006 SHALL have ports: bus_in in 32  resolved shared bus; bus_out out 32, bus_oe out 1  this block's bus drive.
REQ-007 SHALL have ports: reg_idx out 5, reg_en out 1, reg_write out 1  register-file control; busy out 1  high whenever not IDLE.

Function
REQ-008 SHALL be a bus initiator for the register file: reg_en requests the file to drive the bus; reg_write with bus_oe writes bus value into regs[reg_idx] at the next edge.
REQ-009 SHALL implement states IDLE, RD, GAP, WR, RSP (plus RD2/WR2 when SWAP is compiled in).
REQ-010 SHALL assert cmd_ready only in IDLE; a command is accepted on the edge where cmd_valid && cmd_ready.
REQ-011 MOVE SHALL sequence IDLE->RD(reg_idx=rs, reg_en=1, hold<=bus_in)->GAP(no driver)->WR(reg_idx=rd, bus_oe=1, bus_out=hold, reg_write=1)->IDLE; 3 cycles after accept.
REQ-012 LOADI SHALL sequence IDLE->WR(bus_out=cmd_imm registered at accept)->IDLE; 1 cycle after accept.
REQ-013 READ SHALL sequence IDLE->RD(rs)->RSP; rsp_valid=1, rsp_data=hold held stable until rsp_ready, then ->IDLE on that edge.
REQ-014 SHALL never assert reg_en and bus_oe in the same cycle; a GAP cycle SHALL separate any RD followed by WR.
REQ-015 SHALL issue writes to index 0 unchanged on the bus (file discards them); rs=0 reads return 0 from the file.
REQ-016 All outputs SHALL be registered-state decodes; outside their states reg_en, reg_write, bus_oe, rsp_valid = 0, reg_idx = 0, bus_out = 0.
REQ-017 cmd_* inputs SHALL be ignored outside the accept edge; rs/rd/imm latched at accept.

Reset
REQ-018 rst low SHALL immediately force IDLE, cmd_ready=0 while low, busy=0, all bus/control outputs 0, hold=0, rsp_data=0.
REQ-019 Reset mid-operation SHALL abandon the command with no write issued after rst falls; cmd_ready=1 on the first edge after rst rises.

Configuration
REQ-020 Macro REG_XFER_SWAP_EN defined: op 11 = SWAP: RD(rs)->RD2(rd, hold2)->GAP->WR(rd<=hold)->WR2(rs<=hold2)->IDLE; 5 cycles.
REQ-021 Macro REG_XFER_SWAP_EN undefined: op 11 accepted as NOP, returns to IDLE next cycle, no bus activity; RD2/WR2/hold2 absent.

Structure
REQ-022 Package regbus_pkg SHALL hold XLEN=32, REG_IDX_W=5, op enum, and state enum.
REQ-023 SHALL be a single module; no sub-module (bus resolution done at the integrating level).

Verification
REQ-024 LOADI rd=5 imm=0xDEADBEEF -> one cycle later bus_oe=1, reg_idx=5, reg_write=1, bus_out=0xDEADBEEF; model regs[5]=0xDEADBEEF.
REQ-025 MOVE rs=5 rd=7 after REQ-024 -> RD cycle reg_en=1 idx 5, GAP all 0, WR idx 7 bus_out=0xDEADBEEF; regs[7]=0xDEADBEEF.
REQ-026 READ rs=7 with rsp_ready low 4 cycles -> rsp_valid stays 1, rsp_data=0xDEADBEEF stable, cmd_ready=0; drops after rsp_ready edge.
REQ-027 LOADI rd=0 imm=0x12345678 then READ rs=0 -> rsp_data=0x00000000.
REQ-028 rst low during MOVE GAP cycle -> outputs 0 immediately, no reg_write pulse, regs[rd] unchanged; assertion bus_oe&&reg_en never true all tests.
REQ-029 op 11 rs=1 (0x11) rd=2 (0x22): with REG_XFER_SWAP_EN regs[1]=0x22, regs[2]=0x11 after 5 cycles; without, both unchanged, cmd_ready back after 1 cycle.
